alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 24 ++
 rtl/alu_issue_if.sv | 32 +++
 rtl/alu_div_seq.sv | 62 ++++++
 rtl/alu_issue.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue shared definitions.
// Select encodings, FSM state constants and the overflow helper.
package alu_issue_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_DIV  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  function automatic logic ovf_f(
    input logic am,
    input logic bm,
    input logic om
  );
    return (am & bm & ~om) | (~am & ~bm & om);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue request/response bundle.
// Master drives requests, slave is the ALU.
interface alu_issue_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       select;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             sign;
  logic             parity;
  logic             overflow;
  logic             div0;

  modport master (
    output in_valid, a, b, select, out_ready,
    input  in_ready, out_valid, out,
    input  zero, carry, sign, parity, overflow, div0
  );

  modport slave (
    input  in_valid, a, b, select, out_ready,
    output in_ready, out_valid, out,
    output zero, carry, sign, parity, overflow, div0
  );
endinterface

// File: rtl/alu_div_seq.sv
// Iterative restoring divider.
// One quotient bit per cycle, done pulses after WIDTH steps.
module alu_div_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // trial subtract of the divisor from the shifted remainder
  always_comb begin
    shifted = {rem, quotient[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
  end

  // load on start, then shift in one quotient bit per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient <= '0;
      rem      <= '0;
      divisor  <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient <= a;
        rem      <= '0;
        divisor  <= b;
        cnt      <= CW'(WIDTH);
        busy     <= 1'b1;
      end else if (busy) begin
        if (!diff[WIDTH]) begin
          rem      <= diff[WIDTH-1:0];
          quotient <= {quotient[WIDTH-2:0], 1'b1};
        end else begin
          rem      <= shifted[WIDTH-1:0];
          quotient <= {quotient[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/alu_issue.sv
// Single-issue ALU with valid/ready handshake.
// Add/sub/mul finish in one cycle, divide iterates.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_if.slave       io,
  input  logic             clr_sticky,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] op_count
);
  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             hs;
  logic             start;
  logic             fin;
  logic             div_done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH:0]   imm;
  logic             imm_div0;
  logic             ld;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic             res_d0;
  logic             a_msb_q;
  logic             b_msb_q;

  assign io.in_ready  = (state == S_IDLE) |
                        ((state == S_DONE) & io.out_ready);
  assign io.out_valid = (state == S_DONE);
  assign accept = io.in_valid & io.in_ready;
  assign hs     = io.out_valid & io.out_ready;
  assign start  = accept & (io.select == OP_DIV) &
                  (io.b != '0);
  assign fin    = (state == S_DIV) & div_done;

  alu_div_seq #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (io.a),
    .b       (io.b),
    .quotient(quotient),
    .done    (div_done)
  );

  // single-cycle result with carry/borrow in the top bit
  always_comb begin
    imm      = '0;
    imm_div0 = 1'b0;
    unique case (1'b1)
      io.select == OP_ADD:
        imm = {1'b0, io.a} + {1'b0, io.b};
      io.select == OP_SUB:
        imm = {1'b0, io.a} - {1'b0, io.b};
      io.select == OP_MUL:
        imm = {1'b0, io.a} * {1'b0, io.b};
      default: begin
        imm      = {1'b0, {WIDTH{1'b1}}};
        imm_div0 = 1'b1;
      end
    endcase
  end

  // pick between immediate result and finished quotient
  always_comb begin
    ld     = fin | (accept & ~start);
    res    = fin ? quotient : imm[WIDTH-1:0];
    res_c  = fin ? 1'b0 : imm[WIDTH];
    res_d0 = fin ? 1'b0 : imm_div0;
    res_v  = fin ?
      ovf_f(a_msb_q, b_msb_q, quotient[WIDTH-1]) :
      ovf_f(io.a[WIDTH-1], io.b[WIDTH-1], imm[WIDTH-1]);
  end

  // next-state: accept wins, then divide finish, then drain
  always_comb begin
    state_nx = state;
    if (accept)   state_nx = start ? S_DIV : S_DONE;
    else if (fin) state_nx = S_DONE;
    else if (hs)  state_nx = S_IDLE;
  end

  // state and latched operand signs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_msb_q <= io.a[WIDTH-1];
        b_msb_q <= io.b[WIDTH-1];
      end
    end
  end

  // registered result and flags, held until loaded again
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io.out      <= '0;
      io.carry    <= 1'b0;
      io.zero     <= 1'b0;
      io.sign     <= 1'b0;
      io.parity   <= 1'b0;
      io.overflow <= 1'b0;
      io.div0     <= 1'b0;
    end else if (ld) begin
      io.out      <= res;
      io.carry    <= res_c;
      io.zero     <= (res == '0);
      io.sign     <= res[WIDTH-1];
      io.parity   <= ~^res;
      io.overflow <= res_v;
      io.div0     <= res_d0;
    end
  end

  // sticky flags and handshake counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_carry <= 1'b0;
      sticky_ovf   <= 1'b0;
      op_count     <= '0;
    end else begin
      if (hs) begin
        sticky_carry <= io.carry | (sticky_carry & ~clr_sticky);
        sticky_ovf   <= io.overflow | (sticky_ovf & ~clr_sticky);
        op_count     <= op_count + CNT_W'(1);
      end else if (clr_sticky) begin
        sticky_carry <= 1'b0;
        sticky_ovf   <= 1'b0;
      end
    end
  end
endmodule
